// File: rtl/site_stim_pkg.sv
// Shared types and defaults for the site stimulus generator.
// Mode/state encodings and LFSR defaults live here.
package site_stim_pkg;

    typedef enum logic [1:0] {
        WALK1 = 2'd0,
        WALK0 = 2'd1,
        LFSR  = 2'd2,
        CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [15:0] DEF_SEED = 16'hACE1;
    localparam logic [15:0] DEF_TAPS = 16'hB400;

    // A zero LFSR seed would lock up, so it is replaced by 1.
    function automatic logic [63:0] fix_seed(logic [63:0] s, int unsigned w);
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((s & m) == '0) ? 64'd1 : (s & m);
    endfunction

endpackage

// File: rtl/site_stim_if.sv
// Control and stimulus bundle between a sequencer and site_stim_gen.
// master drives the run controls; slave is the generator.
interface site_stim_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NVEC  = 16
) ();

    logic                    start;
    logic                    abort;
    logic [1:0]              mode;
    logic [WIDTH-1:0]        pattern;
    logic [WIDTH-1:0]        stim;
    logic                    stim_valid;
    logic [$clog2(NVEC):0]   vec_idx;
    logic                    busy;
    logic                    done;

    modport master (
        output start, abort, mode, pattern,
        input  stim, stim_valid, vec_idx, busy, done
    );

    modport slave (
        input  start, abort, mode, pattern,
        output stim, stim_valid, vec_idx, busy, done
    );

endinterface

// File: rtl/site_stim_lfsr.sv
// Fibonacci-style shift-left LFSR with load and step controls.
// Shared with the capture compactor, so it stays self-contained.
module site_stim_lfsr
    import site_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter logic [63:0] TAPS  = 64'(DEF_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAP_W = TAPS[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic             fb;

    always_comb begin
        fb     = ^(lfsr_q & TAP_W);
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/site_stim_gen.sv
// Stimulus generator: plays NVEC vectors, each held HOLD cycles,
// in one of four pattern modes, then pulses done for one cycle.
module site_stim_gen
    import site_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NVEC  = 16,
    parameter int unsigned HOLD  = 4,
    parameter logic [63:0] SEED  = 64'(DEF_SEED),
    parameter logic [63:0] TAPS  = 64'(DEF_TAPS)
) (
    input  logic       clk,
    input  logic       rst_n,
    site_stim_if.slave bus
);

    localparam int unsigned IW = $clog2(NVEC) + 1;
    localparam int unsigned HW = $clog2(HOLD) + 1;
    localparam logic [63:0] SEED_FIX = fix_seed(SEED, WIDTH);
    localparam logic [WIDTH-1:0] SEED_W = SEED_FIX[WIDTH-1:0];
    localparam logic [IW-1:0] LAST_IDX = IW'(NVEC - 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] walk_q, walk_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [HW-1:0]    hold_q, hold_d;

    logic             lfsr_ld;
    logic             lfsr_step;
    logic [WIDTH-1:0] lfsr_val;
    logic [WIDTH-1:0] stim_mux;

    site_stim_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_ld),
        .step     (lfsr_step),
        .load_val (SEED_W),
        .q        (lfsr_val)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pat_d     = pat_q;
        walk_d    = walk_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        lfsr_ld   = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    mode_d  = mode_e'(bus.mode);
                    pat_d   = bus.pattern;
                    walk_d  = WIDTH'(1);
                    idx_d   = '0;
                    hold_d  = HOLD_LD;
                    lfsr_ld = 1'b1;
                end
            end
            S_RUN: begin
                // Abort wins over a completion in the same cycle.
                if (bus.abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    hold_d  = '0;
                end else if (hold_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        walk_d    = {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
                        hold_d    = HOLD_LD;
                        lfsr_step = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= WALK1;
            pat_q   <= '0;
            walk_q  <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            walk_q  <= walk_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        stim_mux = '0;
        if (state_q == S_RUN) begin
            unique case (mode_q)
                WALK1:   stim_mux = walk_q;
                WALK0:   stim_mux = ~walk_q;
                LFSR:    stim_mux = lfsr_val;
                CONST:   stim_mux = pat_q;
                default: stim_mux = '0;
            endcase
        end
    end

    assign bus.stim       = stim_mux;
    assign bus.stim_valid = (state_q == S_RUN);
    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.vec_idx    = idx_q;

endmodule
